map_access_arbiter: RTL and testbench

//  Shares the single combinational map lookup port (5 rows x 100 cols, 15-bit entries:
//  [14:12] block_state, [11:0] RGB) between two requesters: the VGA renderer (r0) and
//  the game-logic collision query (r1). Requesters pass a screen-relative column.
//  The block owns the horizontal scroll offset and converts that column to an absolute
//  map column, wrapping mod COLS. Each lookup result is registered and returned one

---
 rtl/map_access_arbiter.sv | 121 ++++++++++++
 tb/tb_map_access_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/map_access_arbiter.sv
// map_access_arbiter
//    Shares one combinational map ROM lookup port between two requesters: the
//    VGA renderer (r0) and the game-logic collision query (r1). Requesters pass a
//    screen-relative column. This block owns the horizontal scroll offset and turns
//    that column into an absolute map column, wrapping modulo COLS. The ROM result
//    is registered and returned one cycle after the grant.
//
// Ports
//    clk, rst            system clock, synchronous active-high reset
//    scroll_step         pulse, advances scroll_col by one (wraps COLS-1 -> 0)
//    scroll_col          absolute map column shown at screen column 0
//    r0_req/row/col      renderer request, held until r0_gnt
//    r0_gnt              renderer granted this cycle (combinational)
//    r0_valid/r0_data    renderer response, one-cycle pulse
//    r1_req/row/col      game-logic request, held until r1_gnt
//    r1_gnt              game-logic granted this cycle (combinational)
//    r1_valid/r1_data    game-logic response, one-cycle pulse
//    rsp_err             alongside a valid pulse: request was out of range, data is 0
//    map_x/map_y         row / absolute column presented to the map ROM
//    map_data            map ROM entry for map_x/map_y
module map_access_arbiter #(
   parameter int ROWS       = 5,
   parameter int COLS       = 100,
   parameter int ROW_W      = 3,
   parameter int COL_W      = 7,
   parameter int DATA_W     = 15,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scroll_step,
   output logic [COL_W-1:0]  scroll_col,
   input  logic              r0_req,
   input  logic [ROW_W-1:0]  r0_row,
   input  logic [COL_W-1:0]  r0_col,
   output logic              r0_gnt,
   output logic              r0_valid,
   output logic [DATA_W-1:0] r0_data,
   input  logic              r1_req,
   input  logic [ROW_W-1:0]  r1_row,
   input  logic [COL_W-1:0]  r1_col,
   output logic              r1_gnt,
   output logic              r1_valid,
   output logic [DATA_W-1:0] r1_data,
   output logic              rsp_err,
   output logic [ROW_W-1:0]  map_x,
   output logic [COL_W-1:0]  map_y,
   input  logic [DATA_W-1:0] map_data
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_cnt;
   logic             starve_hit;
   logic             any_gnt;
   logic [ROW_W-1:0] sel_row;
   logic [COL_W-1:0] sel_col;
   logic             sel_err;
   logic [COL_W:0]   sum;
   logic [COL_W:0]   wrapped;

   // r1 overrides r0 only after it has been denied STARVE_MAX cycles in a row
   assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX)) && r1_req;

   always_comb begin
      r0_gnt = 1'b0;
      r1_gnt = 1'b0;
      if (!rst) begin
         if (r0_req && !starve_hit) begin
            r0_gnt = 1'b1;
         end else if (r1_req) begin
            r1_gnt = 1'b1;
         end
      end
   end

   assign any_gnt = r0_gnt | r1_gnt;
   assign sel_row = r1_gnt ? r1_row : r0_row;
   assign sel_col = r1_gnt ? r1_col : r0_col;
   assign sel_err = (sel_row >= ROW_W'(ROWS)) || (sel_col >= COL_W'(COLS));

   // both operands are below COLS when in range, so one subtraction is enough
   assign sum     = {1'b0, scroll_col} + {1'b0, sel_col};
   assign wrapped = (sum >= (COL_W+1)'(COLS)) ? sum - (COL_W+1)'(COLS) : sum;

   assign map_x = any_gnt ? sel_row : '0;
   assign map_y = any_gnt ? wrapped[COL_W-1:0] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         scroll_col <= '0;
         starve_cnt <= '0;
         r0_valid   <= 1'b0;
         r1_valid   <= 1'b0;
         r0_data    <= '0;
         r1_data    <= '0;
         rsp_err    <= 1'b0;
      end else begin
         if (scroll_step) begin
            scroll_col <= (scroll_col == COL_W'(COLS - 1)) ? '0 : scroll_col + COL_W'(1);
         end

         if (!r1_req || r1_gnt) begin
            starve_cnt <= '0;
         end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end

         r0_valid <= r0_gnt;
         r1_valid <= r1_gnt;
         rsp_err  <= any_gnt & sel_err;
         if (r0_gnt) begin
            r0_data <= sel_err ? '0 : map_data;
         end
         if (r1_gnt) begin
            r1_data <= sel_err ? '0 : map_data;
         end
      end
   end

endmodule

// File: tb/tb_map_access_arbiter.sv
module tb_map_access_arbiter;

   logic        clk;
   logic        rst;
   logic        scroll_step;
   logic [6:0]  scroll_col;
   logic        r0_req, r1_req;
   logic [2:0]  r0_row, r1_row;
   logic [6:0]  r0_col, r1_col;
   logic        r0_gnt, r1_gnt, r0_valid, r1_valid, rsp_err;
   logic [14:0] r0_data, r1_data, map_data;
   logic [2:0]  map_x;
   logic [6:0]  map_y;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int          m_scroll, m_starve;
   logic        pv0, pv1, perr;
   logic [14:0] md0, md1;
   logic        last_g0, last_g1;
   logic [6:0]  last_map_y;

   map_access_arbiter dut (
      .clk(clk), .rst(rst), .scroll_step(scroll_step), .scroll_col(scroll_col),
      .r0_req(r0_req), .r0_row(r0_row), .r0_col(r0_col), .r0_gnt(r0_gnt),
      .r0_valid(r0_valid), .r0_data(r0_data),
      .r1_req(r1_req), .r1_row(r1_row), .r1_col(r1_col), .r1_gnt(r1_gnt),
      .r1_valid(r1_valid), .r1_data(r1_data),
      .rsp_err(rsp_err), .map_x(map_x), .map_y(map_y), .map_data(map_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] rom(input logic [2:0] x, input logic [6:0] y);
      if (x == 3'd0 && y == 7'd20) return 15'h2F00;
      if (x == 3'd2 && y == 7'd0)  return 15'h200F;
      if (x == 3'd1 && y == 7'd3)  return 15'h20F0;
      return {x, 5'b0, y};
   endfunction

   assign map_data = rom(map_x, map_y);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock cycle: checks last cycle's response, applies inputs, checks the
   // grant/address against the model, then advances the model and the clock.
   task automatic run_cycle(input logic rs, input logic st,
                            input logic q0, input logic [2:0] w0, input logic [6:0] c0,
                            input logic q1, input logic [2:0] w1, input logic [6:0] c1);
      logic g0, g1, e0, e1;
      int   y0, y1;
      chk("r0_valid", r0_valid, pv0);
      chk("r1_valid", r1_valid, pv1);
      chk("rsp_err", rsp_err, perr);
      chk("r0_data", r0_data, md0);
      chk("r1_data", r1_data, md1);
      chk("scroll_col", scroll_col, m_scroll);

      rst = rs; scroll_step = st;
      r0_req = q0; r0_row = w0; r0_col = c0;
      r1_req = q1; r1_row = w1; r1_col = c1;
      #1;

      g0 = !rs && q0 && !(m_starve >= 4 && q1);
      g1 = !rs && q1 && !g0;
      e0 = (w0 >= 5) || (c0 >= 100);
      e1 = (w1 >= 5) || (c1 >= 100);
      y0 = (m_scroll + c0) % 100;
      y1 = (m_scroll + c1) % 100;
      chk("r0_gnt", r0_gnt, g0);
      chk("r1_gnt", r1_gnt, g1);
      if (!g0 && !g1) begin
         chk("map_x_idle", map_x, 0);
         chk("map_y_idle", map_y, 0);
      end else if (g0 && !e0) begin
         chk("map_x_r0", map_x, w0);
         chk("map_y_r0", map_y, y0);
      end else if (g1 && !e1) begin
         chk("map_x_r1", map_x, w1);
         chk("map_y_r1", map_y, y1);
      end
      last_g0 = r0_gnt; last_g1 = r1_gnt; last_map_y = map_y;

      if (rs) begin
         m_scroll = 0; m_starve = 0;
         pv0 = 0; pv1 = 0; perr = 0; md0 = '0; md1 = '0;
      end else begin
         pv0  = g0;
         pv1  = g1;
         perr = (g0 && e0) || (g1 && e1);
         if (g0) md0 = e0 ? 15'h0 : rom(w0, 7'(y0));
         if (g1) md1 = e1 ? 15'h0 : rom(w1, 7'(y1));
         if (!q1 || g1) m_starve = 0;
         else if (m_starve < 4) m_starve++;
         if (st) m_scroll = (m_scroll + 1) % 100;
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic rs, st, q0; logic [2:0] w0; logic [6:0] c0;
      logic q1; logic [2:0] w1; logic [6:0] c1;
      logic eg0, eg1, ev0, ev1, eerr; logic [14:0] edata;
   } vec_t;

   vec_t tbl[8];
   logic [9:0] gnt_pat;

   initial begin
      tbl[0] = '{1, 0, 1, 3'd0, 7'd5,   0, 3'd0, 7'd0,  0, 0, 0, 0, 0, 15'h0000};
      tbl[1] = '{0, 0, 0, 3'd0, 7'd0,   1, 3'd0, 7'd20, 0, 1, 0, 1, 0, 15'h2F00};
      tbl[2] = '{0, 0, 0, 3'd0, 7'd0,   1, 3'd5, 7'd0,  0, 1, 0, 1, 1, 15'h0000};
      tbl[3] = '{0, 0, 1, 3'd1, 7'd100, 0, 3'd0, 7'd0,  1, 0, 1, 0, 1, 15'h0000};
      tbl[4] = '{0, 1, 1, 3'd1, 7'd3,   0, 3'd0, 7'd0,  1, 0, 1, 0, 0, 15'h20F0};
      tbl[5] = '{0, 0, 1, 3'd4, 7'd99,  0, 3'd0, 7'd0,  1, 0, 1, 0, 0, 15'h4000};
      tbl[6] = '{0, 0, 1, 3'd0, 7'd0,   1, 3'd1, 7'd1,  1, 0, 1, 0, 0, 15'h0001};
      tbl[7] = '{0, 0, 0, 3'd0, 7'd0,   0, 3'd0, 7'd0,  0, 0, 0, 0, 0, 15'h0000};

      rst = 1; scroll_step = 0;
      r0_req = 0; r0_row = 0; r0_col = 0;
      r1_req = 0; r1_row = 0; r1_col = 0;
      m_scroll = 0; m_starve = 0;
      pv0 = 0; pv1 = 0; perr = 0; md0 = '0; md1 = '0;
      repeat (2) @(posedge clk);
      #1;

      // directed table: reset with a pending request, basic lookups, errors, scroll
      for (int i = 0; i < 8; i++) begin
         run_cycle(tbl[i].rs, tbl[i].st, tbl[i].q0, tbl[i].w0, tbl[i].c0,
                   tbl[i].q1, tbl[i].w1, tbl[i].c1);
         chk($sformatf("tbl%0d_g0", i), last_g0, tbl[i].eg0);
         chk($sformatf("tbl%0d_g1", i), last_g1, tbl[i].eg1);
         chk($sformatf("tbl%0d_v0", i), r0_valid, tbl[i].ev0);
         chk($sformatf("tbl%0d_v1", i), r1_valid, tbl[i].ev1);
         chk($sformatf("tbl%0d_err", i), rsp_err, tbl[i].eerr);
         if (tbl[i].ev0 || tbl[i].rs) chk($sformatf("tbl%0d_d0", i), r0_data, tbl[i].edata);
         if (tbl[i].ev1 || tbl[i].rs) chk($sformatf("tbl%0d_d1", i), r1_data, tbl[i].edata);
         if (i == 4) chk("scroll_after_step", scroll_col, 1);
      end

      // scroll wrap: reset, 99 steps, lookup across the wrap, one more step
      run_cycle(1, 0, 0, 0, 0, 0, 0, 0);
      chk("scroll_reset", scroll_col, 0);
      for (int i = 0; i < 99; i++) run_cycle(0, 1, 0, 0, 0, 0, 0, 0);
      chk("scroll_99", scroll_col, 99);
      run_cycle(0, 0, 1, 3'd2, 7'd1, 0, 0, 0);
      chk("wrap_map_y", last_map_y, 0);
      chk("wrap_data", r0_data, 15'h200F);
      run_cycle(0, 1, 0, 0, 0, 0, 0, 0);
      chk("scroll_wrap_0", scroll_col, 0);

      // starvation: both held for 10 cycles
      for (int i = 0; i < 10; i++) begin
         run_cycle(0, 0, 1, 3'd0, 7'd2, 1, 3'd3, 7'd4);
         gnt_pat[i] = last_g1;
         chk("one_gnt", last_g0 ^ last_g1, 1);
      end
      chk("starve_pattern", gnt_pat, 10'b10000_10000);
      run_cycle(0, 0, 0, 0, 0, 0, 0, 0);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [6:0] c0r, c1r;
         c0r = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(100, 127)) : 7'($urandom_range(0, 99));
         c1r = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(100, 127)) : 7'($urandom_range(0, 99));
         run_cycle($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 9) < 7, 3'($urandom_range(0, 5)), c0r,
                   $urandom_range(0, 9) < 7, 3'($urandom_range(0, 5)), c1r);
      end
      run_cycle(0, 0, 0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
